// File: rtl/pool_out_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pool_out_packer: packs PACK pooled vectors per beat into a valid/ready FIFO.
// Option POOL_OUT_PACKER_STALL_CNT_EN adds STALL_CNT.  Rev 1.0
// ---------------------------------------------------------------------------
module pool_out_packer #(
  parameter int DATA_WIDTH      = 16,
  parameter int NUM_PE          = 4,
  parameter int PACK            = 2,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int COUNTER_WIDTH   = 8
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                START,
  input  logic [COUNTER_WIDTH-1:0]            ROW_VECS,
  input  logic [COUNTER_WIDTH-1:0]            NUM_ROWS,
  input  logic [DATA_WIDTH*NUM_PE-1:0]        DATA_IN,
  input  logic                                IN_VALID,
  output logic [DATA_WIDTH*NUM_PE*PACK-1:0]   M_DATA,
  output logic                                M_VALID,
  input  logic                                M_READY,
  output logic                                M_LAST,
  output logic                                BUSY,
  output logic                                DONE,
  output logic                                OVERFLOW,
  output logic                                DROP
`ifdef POOL_OUT_PACKER_STALL_CNT_EN
  ,
  output logic [31:0]                         STALL_CNT
`endif
);

  localparam int VEC_W  = DATA_WIDTH * NUM_PE;
  localparam int BEAT_W = VEC_W * PACK;
  localparam int DEPTH  = 1 << FIFO_ADDR_WIDTH;
  localparam int CW     = COUNTER_WIDTH;
  localparam logic [CW-1:0] PACK_LAST = CW'(PACK - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]              state;
  logic [CW-1:0]           row_vecs;
  logic [CW-1:0]           num_rows;
  logic [CW-1:0]           pack_cnt;
  logic [CW-1:0]           vec_cnt;
  logic [CW-1:0]           row_cnt;
  logic [BEAT_W-1:0]       pack_buf;
  logic [BEAT_W-1:0]       beat_next;
  logic                    push_pend;
  logic                    push_last;
  logic [BEAT_W-1:0]       push_data;

  logic [BEAT_W:0]         mem [DEPTH];
  logic [FIFO_ADDR_WIDTH:0] wr_ptr;
  logic [FIFO_ADDR_WIDTH:0] rd_ptr;
  logic [BEAT_W:0]         head;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    pop;
  logic                    push;

  logic                    take;
  logic                    row_end;
  logic                    beat_done;
  logic                    job_end;

  // Slot 0 sits in the LSBs; the buffer is zeroed after every beat so a
  // row-end partial beat carries zeros in its unfilled slots.
  always_comb begin
    beat_next = pack_buf;
    for (int i = 0; i < PACK; i++) begin
      if (pack_cnt == CW'(i)) beat_next[i*VEC_W +: VEC_W] = DATA_IN;
    end
  end

  assign take      = (state == S_RUN) && IN_VALID;
  assign row_end   = (vec_cnt == row_vecs - CW'(1));
  assign beat_done = (pack_cnt == PACK_LAST) || row_end;
  assign job_end   = row_end && (row_cnt == num_rows - CW'(1));

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_ADDR_WIDTH] != rd_ptr[FIFO_ADDR_WIDTH]) &&
                      (wr_ptr[FIFO_ADDR_WIDTH-1:0] == rd_ptr[FIFO_ADDR_WIDTH-1:0]);
  assign pop        = M_VALID && M_READY;
  assign push       = push_pend && (!fifo_full || pop);

  assign head    = mem[rd_ptr[FIFO_ADDR_WIDTH-1:0]];
  assign M_VALID = !fifo_empty;
  assign M_DATA  = fifo_empty ? '0 : head[BEAT_W-1:0];
  assign M_LAST  = !fifo_empty && head[BEAT_W];
  assign BUSY    = (state != S_IDLE);
  assign DONE    = (state == S_DRAIN) && fifo_empty && !push_pend;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      row_vecs  <= '0;
      num_rows  <= '0;
      pack_cnt  <= '0;
      vec_cnt   <= '0;
      row_cnt   <= '0;
      pack_buf  <= '0;
      push_pend <= 1'b0;
      push_last <= 1'b0;
      push_data <= '0;
      OVERFLOW  <= 1'b0;
      DROP      <= 1'b0;
    end else begin
      // A completed beat waits one cycle in push_data before entering the FIFO.
      push_pend <= take && beat_done;
      if (take && beat_done) begin
        push_data <= beat_next;
        push_last <= row_end;
      end
      if (push_pend && fifo_full && !pop) OVERFLOW <= 1'b1;

      case (state)
        S_IDLE: begin
          if (IN_VALID) DROP <= 1'b1;
          if (START) begin
            row_vecs <= (ROW_VECS == '0) ? CW'(1) : ROW_VECS;
            num_rows <= (NUM_ROWS == '0) ? CW'(1) : NUM_ROWS;
            pack_cnt <= '0;
            vec_cnt  <= '0;
            row_cnt  <= '0;
            pack_buf <= '0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (take) begin
            if (beat_done) begin
              pack_cnt <= '0;
              pack_buf <= '0;
            end else begin
              pack_cnt <= pack_cnt + CW'(1);
              pack_buf <= beat_next;
            end
            if (row_end) begin
              vec_cnt <= '0;
              row_cnt <= row_cnt + CW'(1);
              if (job_end) state <= S_DRAIN;
            end else begin
              vec_cnt <= vec_cnt + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (IN_VALID) DROP <= 1'b1;
          if (fifo_empty && !push_pend) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // When full, a simultaneous pop frees the head slot that this write reuses.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= {push_last, push_data};
  end

`ifdef POOL_OUT_PACKER_STALL_CNT_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      STALL_CNT <= '0;
    end else if ((state == S_IDLE) && START) begin
      STALL_CNT <= '0;
    end else if (M_VALID && !M_READY && (STALL_CNT != '1)) begin
      STALL_CNT <= STALL_CNT + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pool_out_packer.sv
`default_nettype none
// Testbench for pool_out_packer: job table plus hand sequences, scoreboarded beats.
module tb_pool_out_packer;
  localparam int DW = 16, NPE = 4, PACK = 2, FAW = 2, CW = 8;
  localparam int VEC_W = DW * NPE, BEAT_W = VEC_W * PACK;

  logic              clk = 1'b0;
  logic              RESET = 1'b1, START = 1'b0, IN_VALID = 1'b0, M_READY = 1'b0;
  logic [CW-1:0]     ROW_VECS = '0, NUM_ROWS = '0;
  logic [VEC_W-1:0]  DATA_IN = '0;
  logic [BEAT_W-1:0] M_DATA;
  logic              M_VALID, M_LAST, BUSY, DONE, OVERFLOW, DROP;
`ifdef POOL_OUT_PACKER_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  pool_out_packer #(.DATA_WIDTH(DW), .NUM_PE(NPE), .PACK(PACK),
                    .FIFO_ADDR_WIDTH(FAW), .COUNTER_WIDTH(CW)) dut (
    .CLK(clk), .RESET(RESET), .START(START), .ROW_VECS(ROW_VECS), .NUM_ROWS(NUM_ROWS),
    .DATA_IN(DATA_IN), .IN_VALID(IN_VALID), .M_DATA(M_DATA), .M_VALID(M_VALID),
    .M_READY(M_READY), .M_LAST(M_LAST), .BUSY(BUSY), .DONE(DONE),
    .OVERFLOW(OVERFLOW), .DROP(DROP)
`ifdef POOL_OUT_PACKER_STALL_CNT_EN
    , .STALL_CNT(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [BEAT_W-1:0] data; logic last; } beat_t;
  typedef struct { int rv; int nr; int gap; int exp_beats; } job_t;

  beat_t sb[$];
  int tests = 0, fails = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, pop_cnt = 0, last_pop_cyc = 0;
  int m_rv, m_slot, m_vec, m_k, m_job = 0;
  logic [BEAT_W-1:0] m_beat;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [BEAT_W-1:0] act, logic [BEAT_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Scoreboard: every accepted beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (!RESET) begin
      if (DONE) begin done_cnt++; done_cyc = cyc; end
      if (M_VALID && M_READY) begin
        pop_cnt++;
        last_pop_cyc = cyc;
        if (sb.size() == 0) check("unexpected_beat", M_DATA, '0);
        else begin
          beat_t e;
          e = sb.pop_front();
          check("beat_data", M_DATA, e.data);
          check("beat_last", BEAT_W'(M_LAST), BEAT_W'(e.last));
        end
      end
    end
  end

  function automatic logic [VEC_W-1:0] vec_of(int k);
    logic [VEC_W-1:0] v;
    for (int l = 0; l < NPE; l++) v[l*DW +: DW] = DW'((m_job << 8) + 4*k + NPE - l);
    return v;
  endfunction

  task automatic put_vec(input logic [VEC_W-1:0] v);
    DATA_IN = v; IN_VALID = 1'b1;
    @(posedge clk); #1;
    IN_VALID = 1'b0; DATA_IN = '0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge clk); #1;
    RESET = 1'b0;
    sb.delete();
  endtask

  task automatic start_job(input int rv, input int nr);
    START = 1'b1; ROW_VECS = CW'(rv); NUM_ROWS = CW'(nr);
    @(posedge clk); #1;
    START = 1'b0;
    m_rv = (rv == 0) ? 1 : rv;
    m_slot = 0; m_vec = 0; m_k = 0; m_beat = '0; m_job++;
  endtask

  task automatic send_vec(input int gap);
    logic [VEC_W-1:0] v;
    beat_t b;
    v = vec_of(m_k);
    m_k++;
    m_beat[m_slot*VEC_W +: VEC_W] = v;
    if (m_slot == PACK-1 || m_vec == m_rv-1) begin
      b.data = m_beat; b.last = (m_vec == m_rv-1);
      sb.push_back(b);
      m_beat = '0; m_slot = 0;
    end else m_slot++;
    m_vec = (m_vec == m_rv-1) ? 0 : m_vec + 1;
    put_vec(v);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input int bound);
    int d0, i;
    d0 = done_cnt;
    for (i = 0; i < bound && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) check("done_timeout", 0, 1);
    #1;
  endtask

  task automatic check_outputs_zero(string tag);
    @(negedge clk);
    check({tag, "_m_valid"}, BEAT_W'(M_VALID), 0);
    check({tag, "_m_last"}, BEAT_W'(M_LAST), 0);
    check({tag, "_m_data"}, M_DATA, 0);
    check({tag, "_busy"}, BEAT_W'(BUSY), 0);
    check({tag, "_done"}, BEAT_W'(DONE), 0);
    check({tag, "_overflow"}, BEAT_W'(OVERFLOW), 0);
    check({tag, "_drop"}, BEAT_W'(DROP), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    job_t jobs[5];
    int p0, d0, nv, stall_bad;
    logic [BEAT_W-1:0] first;

    jobs[0] = '{4, 1, 0, 2};
    jobs[1] = '{3, 2, 0, 4};
    jobs[2] = '{1, 3, 1, 3};
    jobs[3] = '{5, 1, 2, 3};
    jobs[4] = '{0, 0, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    RESET = 1'b0;
    check_outputs_zero("reset");

    M_READY = 1'b1;
    foreach (jobs[j]) begin
      p0 = pop_cnt; d0 = done_cnt;
      start_job(jobs[j].rv, jobs[j].nr);
      check("job_busy", BEAT_W'(BUSY), 1);
      nv = ((jobs[j].rv == 0) ? 1 : jobs[j].rv) * ((jobs[j].nr == 0) ? 1 : jobs[j].nr);
      for (int k = 0; k < nv; k++) send_vec(jobs[j].gap);
      wait_done(200);
      repeat (3) begin @(posedge clk); #1; end
      check("job_beats", pop_cnt - p0, jobs[j].exp_beats);
      check("job_done_once", done_cnt - d0, 1);
      check("job_done_timing", done_cyc, last_pop_cyc + 1);
      check("job_idle", BEAT_W'(BUSY), 0);
      check("job_sb_empty", sb.size(), 0);
      check("job_no_overflow", BEAT_W'(OVERFLOW), 0);
    end

    // First beat appears two cycles after its completing vector.
    start_job(2, 1);
    send_vec(0);
    send_vec(0);
    @(negedge clk); check("latency_t1", BEAT_W'(M_VALID), 0);
    @(negedge clk); check("latency_t2", BEAT_W'(M_VALID), 1);
    @(posedge clk); #1;
    wait_done(50);

    // Backpressure: four beats held for 20 cycles.
    M_READY = 1'b0;
    p0 = pop_cnt;
    start_job(8, 1);
    for (int k = 0; k < 8; k++) send_vec(0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    first = M_DATA;
    check("stall_head", first, sb[0].data);
    stall_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!M_VALID || M_DATA !== first) stall_bad++;
    end
    check("stall_stable", stall_bad, 0);
    @(posedge clk); #1;
    M_READY = 1'b1;
    wait_done(100);
    check("stall_beats", pop_cnt - p0, 4);
    check("stall_no_overflow", BEAT_W'(OVERFLOW), 0);

    // Overflow: fifth beat into a full FIFO is lost.
    M_READY = 1'b0;
    p0 = pop_cnt;
    start_job(10, 1);
    for (int k = 0; k < 10; k++) send_vec(0);
    repeat (3) begin @(posedge clk); #1; end
    void'(sb.pop_back());
    check("overflow_set", BEAT_W'(OVERFLOW), 1);
    M_READY = 1'b1;
    wait_done(100);
    check("overflow_beats", pop_cnt - p0, 4);
    check("overflow_sticky", BEAT_W'(OVERFLOW), 1);

    // Push into full FIFO while popping: no loss.
    do_reset();
    M_READY = 1'b0;
    p0 = pop_cnt;
    start_job(10, 1);
    for (int k = 0; k < 8; k++) send_vec(0);
    repeat (3) begin @(posedge clk); #1; end
    send_vec(0);
    send_vec(0);
    M_READY = 1'b1;
    wait_done(100);
    check("full_pushpop_overflow", BEAT_W'(OVERFLOW), 0);
    check("full_pushpop_beats", pop_cnt - p0, 5);

    // Protocol errors: data in IDLE, START while running.
    do_reset();
    p0 = pop_cnt;
    put_vec(64'hDEAD_BEEF_0000_1111);
    stall_bad = 0;
    repeat (4) begin @(negedge clk); if (M_VALID) stall_bad++; end
    check("drop_set", BEAT_W'(DROP), 1);
    check("drop_no_beat", stall_bad, 0);
    @(posedge clk); #1;
    start_job(4, 1);
    send_vec(0);
    START = 1'b1; ROW_VECS = 8'd2; NUM_ROWS = 8'd1;
    send_vec(0);
    START = 1'b0;
    send_vec(0);
    send_vec(0);
    wait_done(100);
    check("start_ignored_beats", pop_cnt - p0, 2);
    check("drop_sticky", BEAT_W'(DROP), 1);

    // Reset mid-job with a beat queued.
    do_reset();
    M_READY = 1'b0;
    start_job(4, 1);
    for (int k = 0; k < 3; k++) send_vec(0);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk); check("midreset_pre_valid", BEAT_W'(M_VALID), 1);
    @(posedge clk); #1;
    do_reset();
    check_outputs_zero("midreset");
    M_READY = 1'b1;
    p0 = pop_cnt; d0 = done_cnt;
    start_job(4, 1);
    for (int k = 0; k < 4; k++) send_vec(0);
    wait_done(100);
    check("after_reset_beats", pop_cnt - p0, 2);
    check("after_reset_done", done_cnt - d0, 1);
    check("after_reset_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
